// File: rtl/cmd_exec.sv
// Command executor: accepts calibrate/move commands, steers to a desired heading and
// ramps forward speed up and down over a counted number of line crossings.
module cmd_exec #(
    parameter logic [9:0]  FRWRD_INC  = 10'h010,
    parameter logic [9:0]  MAX_SPD    = 10'h2A0,
    parameter logic [11:0] ERR_THRESH = 12'h030
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    input  logic        cal_done,
    output logic        strt_cal,
    output logic        moving,
    output logic [9:0]  frwrd,
    output logic [11:0] dsrd_hdg,
    output logic        fanfare_go
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAL     = 3'd1,
        HDG     = 3'd2,
        RAMP_UP = 3'd3,
        RAMP_DN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  frwrd_q, frwrd_d;
    logic [11:0] dsrd_hdg_q, dsrd_hdg_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  sq_q, sq_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ir_s1_q, ir_s2_q, ir_s3_q;
    logic        resp_q, resp_d;
    logic        fan_q, fan_d;
    logic        moving_q, moving_d;

    logic        is_idle, accept, ir_rise, cnt_done, hdg_ok;
    logic [3:0]  cmd_op;
    logic [11:0] hdg_err, hdg_mag;
    logic [10:0] up_sum, dn_step;

    assign cmd_op   = cmd[15:12];
    assign is_idle  = !(state_q inside {CAL, HDG, RAMP_UP, RAMP_DN});
    assign accept   = rst_n && is_idle && cmd_rdy;
    assign ir_rise  = ir_s2_q && !ir_s3_q;
    assign cnt_done = ({1'b0, cnt_q} == {1'b0, sq_q, 1'b0});

    // Heading error wraps mod 2^12; magnitude of -2048 reads as 2048 unsigned.
    assign hdg_err = heading - dsrd_hdg_q;
    assign hdg_mag = hdg_err[11] ? (12'd0 - hdg_err) : hdg_err;
    assign hdg_ok  = (hdg_mag < ERR_THRESH);

    assign up_sum  = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
    assign dn_step = {FRWRD_INC, 1'b0};

    always_comb begin
        state_d     = state_q;
        frwrd_d     = frwrd_q;
        dsrd_hdg_d  = dsrd_hdg_q;
        op_d        = op_q;
        sq_d        = sq_q;
        cnt_d       = ir_rise ? cnt_q + 5'd1 : cnt_q;
        resp_d      = 1'b0;
        fan_d       = 1'b0;
        strt_cal    = 1'b0;
        clr_cmd_rdy = 1'b0;
        case (state_q)
            CAL: begin
                if (cal_done) begin
                    resp_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            HDG: begin
                frwrd_d = '0;
                if (cnt_done) begin
                    state_d = RAMP_DN;
                end else if (heading_rdy && hdg_ok) begin
                    state_d = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (heading_rdy) begin
                    frwrd_d = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
                end
                if (cnt_done) begin
                    state_d = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (frwrd_q == '0) begin
                    resp_d  = 1'b1;
                    fan_d   = (op_q == 4'b0011);
                    state_d = IDLE;
                end else if (heading_rdy) begin
                    frwrd_d = ({1'b0, frwrd_q} < dn_step) ? '0 : frwrd_q - dn_step[9:0];
                end
            end
            default: begin
                state_d = IDLE;
                frwrd_d = '0;
                if (accept) begin
                    clr_cmd_rdy = 1'b1;
                    op_d        = cmd_op;
                    sq_d        = cmd[3:0];
                    if (cmd_op == 4'b0000) begin
                        strt_cal = 1'b1;
                        state_d  = CAL;
                    end else if (cmd_op[3:1] == 3'b001) begin
                        if (cmd[3:0] != '0) begin
                            state_d    = HDG;
                            cnt_d      = '0;
                            dsrd_hdg_d = (cmd[11:4] == '0) ? '0 : {cmd[11:4], 4'hF};
                        end else begin
                            resp_d = 1'b1;
                            fan_d  = cmd_op[0];
                        end
                    end else begin
                        resp_d = 1'b1;
                    end
                end
            end
        endcase
        moving_d = (state_d inside {HDG, RAMP_UP, RAMP_DN});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frwrd_q    <= '0;
            dsrd_hdg_q <= '0;
            op_q       <= '0;
            sq_q       <= '0;
            cnt_q      <= '0;
            ir_s1_q    <= 1'b0;
            ir_s2_q    <= 1'b0;
            ir_s3_q    <= 1'b0;
            resp_q     <= 1'b0;
            fan_q      <= 1'b0;
            moving_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            frwrd_q    <= frwrd_d;
            dsrd_hdg_q <= dsrd_hdg_d;
            op_q       <= op_d;
            sq_q       <= sq_d;
            cnt_q      <= cnt_d;
            ir_s1_q    <= cntrIR;
            ir_s2_q    <= ir_s1_q;
            ir_s3_q    <= ir_s2_q;
            resp_q     <= resp_d;
            fan_q      <= fan_d;
            moving_q   <= moving_d;
        end
    end

    assign send_resp  = resp_q;
    assign fanfare_go = fan_q;
    assign moving     = moving_q;
    assign frwrd      = frwrd_q;
    assign dsrd_hdg   = dsrd_hdg_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Scoreboard bench for cmd_exec: stimulus queues expected accept/response events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cmd_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, moving, fanfare_go;
    logic [11:0] heading = '0;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic        cal_done = 1'b0;
    logic [9:0]  frwrd;
    logic [11:0] dsrd_hdg;

    always #5 clk = ~clk;

    cmd_exec #(
        .FRWRD_INC (10'h010),
        .MAX_SPD   (10'h2A0),
        .ERR_THRESH(12'h030)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp  (send_resp),
        .heading    (heading),
        .heading_rdy(heading_rdy),
        .cntrIR     (cntrIR),
        .cal_done   (cal_done),
        .strt_cal   (strt_cal),
        .moving     (moving),
        .frwrd      (frwrd),
        .dsrd_hdg   (dsrd_hdg),
        .fanfare_go (fanfare_go)
    );

    int vectors = 0;
    int errors  = 0;

    logic acc_exp_q[$];   // expected strt_cal for each accept
    logic resp_exp_q[$];  // expected fanfare_go for each send_resp
    logic mon_e;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (clr_cmd_rdy) begin
            if (acc_exp_q.size() == 0) begin
                check("clr_cmd_rdy with no command expected", clr_cmd_rdy, 0);
            end else begin
                mon_e = acc_exp_q.pop_front();
                check("strt_cal at accept", strt_cal, mon_e);
            end
        end else if (strt_cal) begin
            check("strt_cal without accept", strt_cal, 0);
        end
        if (send_resp) begin
            if (resp_exp_q.size() == 0) begin
                check("send_resp with no response expected", send_resp, 0);
            end else begin
                mon_e = resp_exp_q.pop_front();
                check("fanfare_go with send_resp", fanfare_go, mon_e);
                check("moving at send_resp", moving, 0);
                check("frwrd at send_resp", frwrd, 0);
            end
        end else if (fanfare_go) begin
            check("fanfare_go without send_resp", fanfare_go, 0);
        end
    end

    // Speed-step tracker: phase 1 expects +0x10 steps capped at 0x2A0, phase 2 -0x20 floored at 0.
    int         phase = 0;
    logic [9:0] prev_f = '0;
    always @(negedge clk) begin
        if (frwrd !== prev_f) begin
            if (phase == 1)
                check("ramp-up step", frwrd,
                      (int'(prev_f) + 16 > 'h2A0) ? 'h2A0 : int'(prev_f) + 16);
            else if (phase == 2)
                check("ramp-down step", frwrd,
                      (int'(prev_f) >= 32) ? int'(prev_f) - 32 : 0);
        end
        if (frwrd > 10'h2A0) check("frwrd above ceiling", frwrd, 10'h2A0);
        prev_f = frwrd;
    end

    logic hr_en = 1'b0;
    initial begin
        int hr_cnt;
        hr_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            hr_cnt++;
            heading_rdy = hr_en && (hr_cnt % 8 == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_clr(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (clr_cmd_rdy) break;
            n++;
            if (n > 2000) begin
                check({"accept timeout ", tag}, clr_cmd_rdy, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_rdy = 1'b0;
    endtask

    task automatic issue(input logic [15:0] c, input logic exp_strt, input string tag);
        acc_exp_q.push_back(exp_strt);
        cmd     = c;
        cmd_rdy = 1'b1;
        wait_clr(tag);
    endtask

    // Returns at a negedge with heading strobes disabled.
    task automatic wait_frwrd(input logic [9:0] v, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frwrd !== v && n < budget);
        hr_en = 1'b0;
        check(name, frwrd, v);
    endtask

    task automatic wait_stop(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (moving !== 1'b0 && n < budget);
        check(name, moving, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic ir_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cntrIR = 1'b1;
            tick(3);
            cntrIR = 1'b0;
            tick(3);
        end
    endtask

    initial begin
        #12;
        check("reset frwrd", frwrd, 0);
        check("reset moving", moving, 0);
        check("reset dsrd_hdg", dsrd_hdg, 0);
        check("reset send_resp", send_resp, 0);
        check("reset clr_cmd_rdy", clr_cmd_rdy, 0);
        check("reset strt_cal", strt_cal, 0);
        check("reset fanfare_go", fanfare_go, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Calibration
        issue(16'h0000, 1'b1, "cal");
        tick(9);
        cal_done = 1'b1;
        resp_exp_q.push_back(1'b0);
        @(negedge clk);
        check("cal send_resp not before cal_done registered", send_resp, 0);
        @(posedge clk);
        #1;
        cal_done = 1'b0;
        @(negedge clk);
        check("cal send_resp one cycle after cal_done", send_resp, 1);
        tick(2);

        // Immediate-response commands
        resp_exp_q.push_back(1'b0);
        issue(16'h2000, 1'b0, "2000");
        @(negedge clk);
        check("2000 send_resp next cycle", send_resp, 1);
        check("2000 moving", moving, 0);
        tick(2);
        resp_exp_q.push_back(1'b0);
        issue(16'h7000, 1'b0, "7000");
        @(negedge clk);
        check("7000 send_resp next cycle", send_resp, 1);
        check("7000 moving", moving, 0);
        tick(2);
        resp_exp_q.push_back(1'b1);
        issue(16'h3000, 1'b0, "3000");
        @(negedge clk);
        check("3000 send_resp next cycle", send_resp, 1);
        tick(2);

        // Two-square move at heading 0, full ramp to ceiling
        heading = 12'h000;
        issue(16'h2002, 1'b0, "2002");
        check("2002 dsrd_hdg", dsrd_hdg, 12'h000);
        check("2002 moving", moving, 1);
        phase = 1;
        hr_en = 1'b1;
        wait_frwrd(10'h2A0, 800, "2002 reaches MAX_SPD");
        hr_en = 1'b1;
        tick(40);
        check("2002 saturated at MAX_SPD", frwrd, 10'h2A0);
        hr_en = 1'b0;
        tick(2);
        resp_exp_q.push_back(1'b0);
        ir_pulses(4);
        phase = 2;
        hr_en = 1'b1;
        wait_stop(800, "2002 completes");
        hr_en = 1'b0;
        phase = 0;
        tick(3);

        // Heading gate, fanfare, and command held pending during a move
        heading = 12'h000;
        issue(16'h33F1, 1'b0, "33F1");
        check("33F1 dsrd_hdg", dsrd_hdg, 12'h3FF);
        phase = 1;
        hr_en = 1'b1;
        tick(40);
        check("33F1 held in HDG frwrd", frwrd, 0);
        check("33F1 held in HDG moving", moving, 1);
        heading = 12'h3F0;
        hr_en = 1'b1;
        wait_frwrd(10'h010, 100, "33F1 first ramp step");
        cmd     = 16'h7000;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no clr_cmd_rdy while moving", clr_cmd_rdy, 0);
        end
        hr_en = 1'b1;
        wait_frwrd(10'h040, 200, "33F1 ramps to 0x40");
        tick(2);
        resp_exp_q.push_back(1'b1);
        resp_exp_q.push_back(1'b0);
        acc_exp_q.push_back(1'b0);
        ir_pulses(2);
        phase = 2;
        hr_en = 1'b1;
        wait_clr("pending 7000");
        @(negedge clk);
        check("pending 7000 send_resp", send_resp, 1);
        check("pending 7000 moving", moving, 0);
        hr_en = 1'b0;
        phase = 0;
        tick(3);

        // Reset mid-ramp, then a pending command after release
        heading = 12'h000;
        issue(16'h2001, 1'b0, "2001 abandoned");
        phase = 1;
        hr_en = 1'b1;
        wait_frwrd(10'h150, 600, "2001 ramps to 0x150");
        #1;
        phase = 0;
        rst_n = 1'b0;
        #1;
        check("async reset frwrd", frwrd, 0);
        check("async reset moving", moving, 0);
        cmd     = 16'h2001;
        cmd_rdy = 1'b1;
        tick(3);
        check("no clr_cmd_rdy in reset", clr_cmd_rdy, 0);
        acc_exp_q.push_back(1'b0);
        rst_n = 1'b1;
        wait_clr("2001 after reset");
        check("2001 dsrd_hdg", dsrd_hdg, 12'h000);
        check("2001 moving", moving, 1);
        phase = 1;
        hr_en = 1'b1;
        wait_frwrd(10'h030, 200, "2001 ramps to 0x30");
        tick(2);
        resp_exp_q.push_back(1'b0);
        ir_pulses(2);
        phase = 2;
        hr_en = 1'b1;
        wait_stop(400, "2001 completes");
        hr_en = 1'b0;
        phase = 0;
        tick(5);

        check("accept expectations drained", acc_exp_q.size(), 0);
        check("response expectations drained", resp_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
